// File: rtl/led_blinker_multi.sv
// N-channel LED driver: a shared prescaler produces a slow tick, and each channel runs
// its own OFF / ON / BLINK / ONESHOT mode with a runtime-programmable period in ticks.
module led_blinker_multi #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TICK_HZ      = 1000,
  parameter int unsigned PER_W        = 16,
  parameter int unsigned RESET_MODE   = 2,
  parameter int unsigned RESET_PERIOD = 500,
  parameter int unsigned ACTIVE_LOW   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  output logic              cfg_err,
  output logic              tick,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] led
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W    = $clog2(TICK_DIV);

  localparam logic [PRE_W-1:0] PreLast = PRE_W'(TICK_DIV - 1);
  localparam logic             Inv     = (ACTIVE_LOW != 0);
  localparam logic [PER_W-1:0] RstPer  = PER_W'(RESET_PERIOD);

  typedef enum logic [1:0] {
    ModeOff     = 2'd0,
    ModeOn      = 2'd1,
    ModeBlink   = 2'd2,
    ModeOneshot = 2'd3
  } mode_e;

  localparam mode_e RstMode = mode_e'(2'(RESET_MODE));

  logic [PRE_W-1:0] presc_q;

  // Prescaler, registered tick and out-of-range write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      tick    <= (presc_q == PreLast);
      presc_q <= (presc_q == PreLast) ? '0 : presc_q + 1'b1;
      cfg_err <= cfg_we && (32'(cfg_ch) >= NUM_CH);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e            mode_q, mode_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] eff_p;
    logic             st_q, st_d;
    logic             done_q, done_d;
    logic             led_q;
    logic             wr_hit;
    logic             at_last;

    assign wr_hit  = cfg_we && (cfg_ch == 5'(i));
    // A programmed period of 0 behaves as 1 so the counter never runs the full range.
    assign eff_p   = (per_q == '0) ? PER_W'(1) : per_q;
    assign at_last = (cnt_q == eff_p - PER_W'(1));

    // Next-state: a write takes precedence over a coincident tick for this channel.
    always_comb begin
      mode_d = mode_q;
      per_d  = per_q;
      cnt_d  = cnt_q;
      st_d   = st_q;
      done_d = 1'b0;
      if (wr_hit) begin
        mode_d = mode_e'(cfg_mode);
        per_d  = cfg_period;
        cnt_d  = '0;
        st_d   = (cfg_mode != 2'd0);
      end else if (tick) begin
        unique case (mode_q)
          ModeBlink: begin
            if (at_last) begin
              cnt_d = '0;
              st_d  = ~st_q;
            end else begin
              cnt_d = cnt_q + PER_W'(1);
            end
          end
          ModeOneshot: begin
            if (at_last) begin
              cnt_d  = '0;
              st_d   = 1'b0;
              mode_d = ModeOff;
              done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + PER_W'(1);
            end
          end
          ModeOff, ModeOn: cnt_d = '0;
        endcase
      end
    end

    // Channel state; the pin register follows the next logical state directly.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q <= RstMode;
        per_q  <= RstPer;
        cnt_q  <= '0;
        st_q   <= 1'b0;
        done_q <= 1'b0;
        led_q  <= Inv;
      end else begin
        mode_q <= mode_d;
        per_q  <= per_d;
        cnt_q  <= cnt_d;
        st_q   <= st_d;
        done_q <= done_d;
        led_q  <= st_d ^ Inv;
      end
    end

    assign done[i] = done_q;
    assign led[i]  = led_q;
  end

endmodule
